// File: rtl/sprite_line_drawer_if.sv
// Draw-request channel between the sprite front-end (master) and the line drawer (slave).
// The request is a single-cycle draw_req pulse with its fields. The master may pulse it only while busy is low.
// busy rises combinationally with draw_req, so the request is accepted in that same cycle.
// draw_done pulses on the last pixel slot of the request. req_overrun latches any request that arrives while the drawer is occupied.
interface sprite_line_drawer_if;
   logic       draw_req;
   logic [9:0] col_base;
   logic       flip;
   logic [7:0] frame_id;
   logic [3:0] row_off;
   logic       busy;
   logic       draw_done;
   logic       req_overrun;

   modport master (
      output draw_req, col_base, flip, frame_id, row_off,
      input  busy, draw_done, req_overrun
   );

   modport slave (
      input  draw_req, col_base, flip, frame_id, row_off,
      output busy, draw_done, req_overrun
   );
endinterface

// File: rtl/sprite_line_drawer.sv
// Sprite row drawer: fetches 16 pattern pixels per request and writes the opaque,
// on-screen, not-yet-claimed ones into the line buffer (first writer wins per line).
module sprite_line_drawer #(
   parameter int PIXW     = 8,
   parameter int SCREEN_W = 640,
   parameter int SPR_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_row,
   sprite_line_drawer_if.slave  drw,
   output logic [15:0]          rom_addr,
   input  logic [PIXW-1:0]      rom_data,
   output logic                 lb_we,
   output logic [9:0]           lb_addr,
   output logic [PIXW-1:0]      lb_wdata,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [9:0]      col_q;
   logic            flip_q;
   logic [7:0]      frame_q;
   logic [3:0]      row_q;
   logic [3:0]      px_q;
   logic            s1_valid_q;
   logic            s1_last_q;
   logic [10:0]     s1_x_q;
   logic [1023:0]   occ_q;
   logic [9:0]      lb_addr_q;
   logic [PIXW-1:0] lb_wdata_q;
   logic            overrun_q;
   logic            accept;
   logic            fetch_last;
   logic [3:0]      px_col;
   logic [10:0]     x_next;

   assign accept     = drw.draw_req && !start_row && (state_q == S_IDLE);
   assign fetch_last = (state_q == S_FETCH) && (px_q == 4'(SPR_W - 1));
   assign px_col     = flip_q ? (4'(SPR_W - 1) - px_q) : px_q;
   assign x_next     = {1'b0, col_q} + 11'(px_col);

   assign drw.busy        = drw.draw_req || (state_q != S_IDLE);
   assign drw.req_overrun = overrun_q;
   assign drw.draw_done   = s1_valid_q && s1_last_q && !start_row;
   assign rom_addr        = {frame_q, row_q, px_q};
   assign dbg_state       = state_q;

   // Write stage: the ROM word for the pixel in s1 arrives this cycle.
   assign lb_we    = s1_valid_q && !start_row && (rom_data != '0) &&
                     (s1_x_q < 11'(SCREEN_W)) && !occ_q[s1_x_q[9:0]];
   assign lb_addr  = lb_we ? s1_x_q[9:0] : lb_addr_q;
   assign lb_wdata = lb_we ? rom_data : lb_wdata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start_row) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (drw.draw_req) state_d = S_FETCH;
            S_FETCH: if (fetch_last) state_d = S_DRAIN;
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q      <= '0;
         flip_q     <= 1'b0;
         frame_q    <= '0;
         row_q      <= '0;
         px_q       <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_x_q     <= '0;
         occ_q      <= '0;
         lb_addr_q  <= '0;
         lb_wdata_q <= '0;
         overrun_q  <= 1'b0;
      end else begin
         if (accept) begin
            col_q   <= drw.col_base;
            flip_q  <= drw.flip;
            frame_q <= drw.frame_id;
            row_q   <= drw.row_off;
            px_q    <= '0;
         end else if (start_row) begin
            px_q <= '0;
         end else if (state_q == S_FETCH) begin
            px_q <= px_q + 4'd1;
         end

         s1_valid_q <= !start_row && (state_q == S_FETCH);
         s1_last_q  <= fetch_last;
         s1_x_q     <= x_next;

         if (start_row)  occ_q <= '0;
         else if (lb_we) occ_q[s1_x_q[9:0]] <= 1'b1;

         if (lb_we) begin
            lb_addr_q  <= s1_x_q[9:0];
            lb_wdata_q <= rom_data;
         end

         // A request dropped by start_row is not an overrun.
         if (drw.draw_req && !start_row && (state_q != S_IDLE)) overrun_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sprite_line_drawer.sv
// Bench for sprite_line_drawer: directed scenarios plus randomized requests, checked
// against a per-line occupancy/ROM model and an expected-write queue.
module tb_sprite_line_drawer;
   localparam int PIXW     = 8;
   localparam int SCREEN_W = 640;

   logic            clk = 1'b0;
   logic            reset;
   logic            start_row;
   logic [15:0]     rom_addr;
   logic [PIXW-1:0] rom_data = '0;
   logic            lb_we;
   logic [9:0]      lb_addr;
   logic [PIXW-1:0] lb_wdata;
   logic [1:0]      dbg_state;

   sprite_line_drawer_if drw();

   sprite_line_drawer #(.PIXW(PIXW), .SCREEN_W(SCREEN_W), .SPR_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .start_row (start_row),
      .drw       (drw),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .lb_we     (lb_we),
      .lb_addr   (lb_addr),
      .lb_wdata  (lb_wdata),
      .dbg_state (dbg_state)
   );

   // clock / reset / ROM
   always #5 clk = ~clk;

   logic [PIXW-1:0] rom_mem [0:65535];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   // model and scoreboard state
   bit              occ_m  [SCREEN_W];
   logic [PIXW-1:0] lb_mem [1024];
   logic [17:0]     exp_q[$];
   logic [17:0]     mon_e;
   int              n_checks = 0;
   int              n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void clear_line();
      for (int x = 0; x < SCREEN_W; x++) occ_m[x] = 1'b0;
      for (int x = 0; x < 1024; x++) lb_mem[x] = '0;
   endfunction

   // every line-buffer write must match the head of the expected queue
   always @(negedge clk) begin
      if (!reset && lb_we === 1'b1) begin
         check("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("lb_addr", 32'(lb_addr), 32'(mon_e[17:8]));
            check("lb_wdata", 32'(lb_wdata), 32'(mon_e[7:0]));
         end
         lb_mem[lb_addr] = lb_wdata;
      end
   end

   // mode 0: i+1, 1: i, 2: constant, other: random with ~25% transparent
   task automatic fill_row(input logic [7:0] frm, input logic [3:0] row, input int mode,
                           input logic [7:0] val);
      for (int i = 0; i < 16; i++) begin
         logic [7:0] d;
         case (mode)
            0:       d = 8'(i + 1);
            1:       d = 8'(i);
            2:       d = val;
            default: d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         endcase
         rom_mem[{frm, row, 4'(i)}] = d;
      end
   endtask

   task automatic new_line(input bit with_req);
      start_row = 1'b1;
      if (with_req) begin
         drw.draw_req = 1'b1;
         drw.col_base = 10'd20;
      end
      @(negedge clk);
      check("sr_lb_we", 32'(lb_we), 32'd0);
      check("sr_draw_done", 32'(drw.draw_done), 32'd0);
      @(posedge clk); #1;
      start_row    = 1'b0;
      drw.draw_req = 1'b0;
      clear_line();
      if (with_req) begin
         @(negedge clk);
         check("sr_req_dropped_busy", 32'(drw.busy), 32'd0);
         check("sr_req_no_overrun", 32'(drw.req_overrun), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   // One request; abort_k / extra_k (cycles after acceptance) inject start_row / a second request.
   task automatic do_draw(input logic [9:0] col, input logic flp, input logic [7:0] frm,
                          input logic [3:0] row, input int abort_k, input int extra_k);
      logic exp_we [16];
      for (int i = 0; i < 16; i++) begin
         int x;
         logic [PIXW-1:0] d;
         x = col + (flp ? 15 - i : i);
         d = rom_mem[{frm, row, 4'(i)}];
         exp_we[i] = 1'b0;
         if ((abort_k < 0 || 2 + i < abort_k) && d != 0 && x < SCREEN_W && !occ_m[x]) begin
            exp_we[i] = 1'b1;
            occ_m[x]  = 1'b1;
            exp_q.push_back({10'(x), d});
         end
      end

      drw.draw_req = 1'b1;
      drw.col_base = col;
      drw.flip     = flp;
      drw.frame_id = frm;
      drw.row_off  = row;
      @(negedge clk);
      check("busy_on_req", 32'(drw.busy), 32'd1);
      @(posedge clk); #1;
      drw.draw_req = 1'b0;

      for (int k = 1; k <= 18; k++) begin
         logic aborted;
         logic exp_busy;
         if (k == extra_k) begin
            drw.draw_req = 1'b1;
            drw.col_base = 10'($urandom_range(0, 639));
         end
         if (k == abort_k) start_row = 1'b1;
         @(negedge clk);
         aborted  = (abort_k >= 0) && (k >= abort_k);
         exp_busy = drw.draw_req || (k <= 17 && !(abort_k >= 0 && k > abort_k));
         if (k <= 16 && !aborted) check("rom_addr", 32'(rom_addr), 32'({frm, row, 4'(k - 1)}));
         check("busy", 32'(drw.busy), 32'(exp_busy));
         check("draw_done", 32'(drw.draw_done), 32'(k == 17 && !aborted));
         check("lb_we", 32'(lb_we), (k >= 2 && k <= 17 && !aborted) ? 32'(exp_we[k - 2]) : 32'd0);
         @(posedge clk); #1;
         drw.draw_req = 1'b0;
         if (start_row) begin
            start_row = 1'b0;
            clear_line();
         end
      end
      if (extra_k > 0) check("req_overrun_set", 32'(drw.req_overrun), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 65536; a++) rom_mem[a] = '0;
      clear_line();
      reset        = 1'b1;
      start_row    = 1'b0;
      drw.draw_req = 1'b0;
      drw.col_base = '0;
      drw.flip     = 1'b0;
      drw.frame_id = '0;
      drw.row_off  = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(drw.busy), 32'd0);
      check("rst_lb_we", 32'(lb_we), 32'd0);
      check("rst_lb_addr", 32'(lb_addr), 32'd0);
      check("rst_lb_wdata", 32'(lb_wdata), 32'd0);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_draw_done", 32'(drw.draw_done), 32'd0);
      check("rst_overrun", 32'(drw.req_overrun), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // basic
      new_line(1'b0);
      fill_row(8'd3, 4'd5, 0, 8'h00);
      do_draw(10'd100, 1'b0, 8'd3, 4'd5, -1, -1);
      for (int x = 100; x < 116; x++) check("basic_lb", 32'(lb_mem[x]), 32'(x - 99));

      // flip and transparency, with a draw_req dropped by start_row
      new_line(1'b1);
      fill_row(8'd4, 4'd1, 1, 8'h00);
      do_draw(10'd200, 1'b1, 8'd4, 4'd1, -1, -1);
      check("flip_transparent", 32'(lb_mem[215]), 32'd0);
      for (int x = 200; x < 215; x++) check("flip_lb", 32'(lb_mem[x]), 32'(215 - x));

      // priority / occupancy
      new_line(1'b0);
      fill_row(8'h10, 4'd0, 2, 8'hAA);
      fill_row(8'h11, 4'd0, 2, 8'hBB);
      do_draw(10'd50, 1'b0, 8'h10, 4'd0, -1, -1);
      do_draw(10'd58, 1'b0, 8'h11, 4'd0, -1, -1);
      for (int x = 50; x < 66; x++) check("prio_a", 32'(lb_mem[x]), 32'hAA);
      for (int x = 66; x < 74; x++) check("prio_b", 32'(lb_mem[x]), 32'hBB);
      new_line(1'b0);
      do_draw(10'd58, 1'b0, 8'h11, 4'd0, -1, -1);
      for (int x = 58; x < 74; x++) check("prio_b_alone", 32'(lb_mem[x]), 32'hBB);

      // right edge
      new_line(1'b0);
      fill_row(8'h20, 4'd7, 2, 8'h33);
      do_draw(10'd630, 1'b0, 8'h20, 4'd7, -1, -1);
      for (int x = 630; x < 640; x++) check("edge_lb", 32'(lb_mem[x]), 32'h33);
      check("edge_q_empty", 32'(exp_q.size()), 32'd0);

      // overrun, then abort of a fresh request
      new_line(1'b0);
      fill_row(8'h30, 4'd2, 3, 8'h00);
      do_draw(10'd400, 1'b0, 8'h30, 4'd2, -1, 5);
      do_draw(10'd420, 1'b1, 8'h30, 4'd2, 8, -1);
      check("overrun_sticky", 32'(drw.req_overrun), 32'd1);

      // randomized requests
      for (int n = 0; n < 40; n++) begin
         logic [9:0] col;
         logic [7:0] frm;
         logic [3:0] row;
         int         ab;
         if ($urandom_range(0, 4) == 0) new_line(1'b0);
         col = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(600, 639))
                                           : 10'($urandom_range(0, 639));
         frm = 8'($urandom_range(0, 255));
         row = 4'($urandom_range(0, 15));
         ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 16)) : -1;
         fill_row(frm, row, 3, 8'h00);
         do_draw(col, 1'($urandom_range(0, 1)), frm, row, ab, -1);
      end

      // asynchronous reset in the middle of a fetch
      new_line(1'b0);
      fill_row(8'h07, 4'h2, 2, 8'h5A);
      for (int i = 0; i < 4; i++) exp_q.push_back({10'(300 + i), 8'h5A});
      drw.draw_req = 1'b1;
      drw.col_base = 10'd300;
      drw.flip     = 1'b0;
      drw.frame_id = 8'h07;
      drw.row_off  = 4'h2;
      @(posedge clk); #1;
      drw.draw_req = 1'b0;
      for (int k = 1; k < 6; k++) begin
         if (k == 3) drw.draw_req = 1'b1;
         @(posedge clk); #1;
         drw.draw_req = 1'b0;
      end
      check("arst_pre_lb_we", 32'(lb_we), 32'd1);
      check("arst_pre_overrun", 32'(drw.req_overrun), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("arst_busy", 32'(drw.busy), 32'd0);
      check("arst_lb_we", 32'(lb_we), 32'd0);
      check("arst_overrun", 32'(drw.req_overrun), 32'd0);
      check("arst_state", 32'(dbg_state), 32'd0);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      for (int x = 0; x < SCREEN_W; x++) occ_m[x] = 1'b0;
      do_draw(10'd300, 1'b0, 8'h07, 4'h2, -1, -1);
      for (int x = 300; x < 316; x++) check("arst_redraw", 32'(lb_mem[x]), 32'h5A);

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
